vx_perf_mem_monitor: RTL
========================

// Module: vx_perf_mem_monitor
// PURPOSE
//  Parametrised memory-system performance monitor: observes NUM_REQS memory request/response
//  channels and produces the read, write, latency and stall counters the perf-CSR block reads.
//  Successor to the fixed-width memsys counter bundle: adds per-channel outstanding tracking,
//  peak-outstanding capture, counting enable, synchronous clear and selectable saturating counters.
// PARAMETERS
//  NUM_REQS      4   number of monitored memory channels (1..16)
//  CTR_BITS      44  width of every event counter
//  PENDING_BITS  8   width of each per-channel outstanding-read counter
//  SATURATE      0   0: counters wrap modulo 2^CTR_BITS; 1: counters stick at all-ones
// PORTS
//  clk          in   1                     clock
//  reset        in   1                     synchronous, active-high reset
//  enable       in   1                     1: event counters advance; 0: event counters hold
//  clear        in   1                     synchronous clear of event counters and peak
//  req_valid    in   NUM_REQS              per-channel request valid
//  req_ready    in   NUM_REQS              per-channel request ready
//  req_rw       in   NUM_REQS              per-channel request type, 1 = write, 0 = read
//  rsp_valid    in   NUM_REQS              per-channel read response valid
//  rsp_ready    in   NUM_REQS              per-channel read response ready
//  mem_reads    out  CTR_BITS              accepted read requests
//  mem_writes   out  CTR_BITS              accepted write requests
//  mem_stalls   out  CTR_BITS              channel-cycles with req_valid & ~req_ready
//  mem_latency  out  CTR_BITS              sum over cycles of total outstanding reads
//  peak_pending out  PENDING_BITS+4        max total outstanding reads seen since clear
//  overflow     out  1                     sticky: pending counter saturated or underflowed
// BEHAVIOUR
//  - Reset: all outputs, all per-channel pending counters and overflow = 0.
//  - Fire terms per channel i: rd_fire = req_valid&req_ready&~req_rw; wr_fire = req_valid&
//    req_ready&req_rw; stall = req_valid&~req_ready; rsp_fire = rsp_valid&rsp_ready.
//  - Per cycle (enable=1, clear=0): mem_reads += popcount(rd_fire); mem_writes += popcount(wr_fire);
//    mem_stalls += popcount(stall); mem_latency += PEND, PEND = sum of registered pending[i]
//    (value at start of the cycle, before this cycle's update). All adds use one adder per counter.
//  - Latency: an event in cycle N is visible on outputs at cycle N+1; outputs are registers.
//  - pending[i]: +1 on rd_fire only, -1 on rsp_fire only, unchanged if both or neither.
//    Tracked regardless of enable and clear (reflects real outstanding traffic).
//  - pending[i] at 2^PENDING_BITS-1 with increment: holds, overflow <= 1.
//  - pending[i] at 0 with rsp_fire and no rd_fire: holds at 0, overflow <= 1.
//  - peak_pending <= max(peak_pending, PEND) every cycle with enable=1.
//  - SATURATE=0: counter wraps modulo 2^CTR_BITS. SATURATE=1: if sum exceeds all-ones, result
//    = all-ones and stays there until clear/reset; overflow unaffected by counter saturation.
//  - clear=1: mem_reads/writes/stalls/latency, peak_pending and overflow <= 0 next cycle; clear
//    beats same-cycle increments (those events are dropped). reset beats clear.
//  - enable=0: event counters and peak hold; clear still acts.
//  - Reset asserted mid-traffic: responses arriving after reset for pre-reset reads hit the
//    underflow rule (pending held at 0, overflow set); software clears before sampling.
// TESTING
//  - 3 read fires ch0, 2 write fires ch1 over 5 cycles -> mem_reads=3, mem_writes=2 one cycle after.
//  - Read on ch0 at cycle 0, response fires cycle 10 -> mem_latency=10, peak_pending=1, pending back 0.
//  - ch2 req_valid=1, req_ready=0 for 7 cycles, enable drops for 3 of them -> mem_stalls=4.
//  - rd_fire and rsp_fire same cycle on ch3 with pending=2 -> pending stays 2; latency +2 per cycle.
//  - CTR_BITS=4, SATURATE=1, 20 read fires -> mem_reads=15; SATURATE=0 -> mem_reads=4.
//  - rsp_fire with pending=0 -> overflow=1; clear pulse concurrent with read fire -> all counts 0.

Source files
------------

// File: rtl/vx_perf_mem_monitor.sv
// vx_perf_mem_monitor
//   Memory-system performance monitor. Watches NUM_REQS request/response
//   channels and keeps the read, write, stall and latency event counters, a
//   peak total-outstanding capture and a sticky pending-tracker overflow flag.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   enable              1: event counters / peak advance, 0: they hold
//   clear               synchronous clear of event counters, peak and overflow
//   req_valid/ready/rw  per-channel request handshake and type (1 = write)
//   rsp_valid/ready     per-channel read response handshake
//   mem_reads/writes    accepted read / write requests
//   mem_stalls          channel-cycles with req_valid & ~req_ready
//   mem_latency         sum over cycles of total outstanding reads
//   peak_pending        max total outstanding reads since clear
//   overflow            sticky: a pending counter saturated or underflowed
module vx_perf_mem_monitor #(
    parameter int NUM_REQS     = 4,
    parameter int CTR_BITS     = 44,
    parameter int PENDING_BITS = 8,
    parameter int SATURATE     = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS-1:0]       req_ready,
    input  logic [NUM_REQS-1:0]       req_rw,
    input  logic [NUM_REQS-1:0]       rsp_valid,
    input  logic [NUM_REQS-1:0]       rsp_ready,
    output logic [CTR_BITS-1:0]       mem_reads,
    output logic [CTR_BITS-1:0]       mem_writes,
    output logic [CTR_BITS-1:0]       mem_stalls,
    output logic [CTR_BITS-1:0]       mem_latency,
    output logic [PENDING_BITS+3:0]   peak_pending,
    output logic                      overflow
);

    // 4 extra bits hold the sum of up to 16 channels' pending counts.
    localparam int PEND_W = PENDING_BITS + 4;
    // Adder width: wide enough for either operand plus a carry, so the
    // saturating compare sees the true sum even when CTR_BITS is small.
    localparam int SUM_W  = ((CTR_BITS > PEND_W) ? CTR_BITS : PEND_W) + 1;
    localparam logic [SUM_W-1:0] CTR_MAX = (SUM_W'(1) << CTR_BITS) - SUM_W'(1);

    logic [NUM_REQS-1:0]              rd_fire, wr_fire, stall, rsp_fire, ovf_evt;
    logic [NUM_REQS*PENDING_BITS-1:0] pending_flat;

    assign rd_fire  = req_valid & req_ready & ~req_rw;
    assign wr_fire  = req_valid & req_ready & req_rw;
    assign stall    = req_valid & ~req_ready;
    assign rsp_fire = rsp_valid & rsp_ready;

    // Per-channel outstanding-read trackers; these follow real traffic and
    // ignore enable/clear. Only reset zeroes them.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQS; gi++) begin : g_pend
            logic [PENDING_BITS-1:0] pending_reg;
            logic                    inc, dec;

            assign inc = rd_fire[gi] & ~rsp_fire[gi];
            assign dec = rsp_fire[gi] & ~rd_fire[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    pending_reg <= '0;
                end else if (inc && (pending_reg != '1)) begin
                    pending_reg <= pending_reg + PENDING_BITS'(1);
                end else if (dec && (pending_reg != '0)) begin
                    pending_reg <= pending_reg - PENDING_BITS'(1);
                end
            end

            assign ovf_evt[gi] = (inc && (pending_reg == '1)) ||
                                 (dec && (pending_reg == '0));
            assign pending_flat[gi*PENDING_BITS +: PENDING_BITS] = pending_reg;
        end
    endgenerate

    logic [SUM_W-1:0]  rd_cnt, wr_cnt, st_cnt;
    logic [PEND_W-1:0] pend_sum;

    always_comb begin
        rd_cnt   = '0;
        wr_cnt   = '0;
        st_cnt   = '0;
        pend_sum = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            rd_cnt   = rd_cnt + SUM_W'(rd_fire[i]);
            wr_cnt   = wr_cnt + SUM_W'(wr_fire[i]);
            st_cnt   = st_cnt + SUM_W'(stall[i]);
            pend_sum = pend_sum + PEND_W'(pending_flat[i*PENDING_BITS +: PENDING_BITS]);
        end
    end

    // One adder per counter; saturation clamps to all-ones, otherwise wrap.
    function automatic logic [CTR_BITS-1:0] ctr_add(input logic [CTR_BITS-1:0] base,
                                                    input logic [SUM_W-1:0]    inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + inc;
        if ((SATURATE != 0) && (sum > CTR_MAX)) begin
            return '1;
        end
        return sum[CTR_BITS-1:0];
    endfunction

    logic [CTR_BITS-1:0] reads_reg, writes_reg, stalls_reg, latency_reg;
    logic [PEND_W-1:0]   peak_reg;
    logic                overflow_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            reads_reg    <= '0;
            writes_reg   <= '0;
            stalls_reg   <= '0;
            latency_reg  <= '0;
            peak_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (enable) begin
                reads_reg   <= ctr_add(reads_reg, rd_cnt);
                writes_reg  <= ctr_add(writes_reg, wr_cnt);
                stalls_reg  <= ctr_add(stalls_reg, st_cnt);
                latency_reg <= ctr_add(latency_reg, SUM_W'(pend_sum));
                if (pend_sum > peak_reg) begin
                    peak_reg <= pend_sum;
                end
            end
            if (|ovf_evt) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign mem_reads    = reads_reg;
    assign mem_writes   = writes_reg;
    assign mem_stalls   = stalls_reg;
    assign mem_latency  = latency_reg;
    assign peak_pending = peak_reg;
    assign overflow     = overflow_reg;

endmodule
